// File: rtl/rx_agc.sv
// rx_agc: runtime I/Q gain with round/saturate, closed by a windowed |I|+|Q| AGC loop.
// Latency 2 cycles din_valid->dout_valid; no backpressure, the pipeline advances every cycle.
module rx_agc #(
  parameter int DATA_WIDTH   = 12,
  parameter int GAIN_WIDTH   = 16,
  parameter int GAIN_FRAC    = 10,
  parameter int GAIN_INIT    = 1443,
  parameter int WIN_LOG2     = 6,
  parameter int TARGET       = 1024,
  parameter int MU_ACQ_SHIFT = 4,
  parameter int MU_TRK_SHIFT = 7,
  parameter int LOCK_TOL     = 128,
  parameter int LOCK_WINS    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] din_I,
  input  logic signed [DATA_WIDTH-1:0] din_Q,
  input  logic                         din_valid,
  input  logic                         agc_en,
  input  logic                         freeze,
  input  logic                         gain_load,
  input  logic [GAIN_WIDTH-1:0]        gain_load_val,
  output logic signed [DATA_WIDTH-1:0] dout_I,
  output logic signed [DATA_WIDTH-1:0] dout_Q,
  output logic                         dout_valid,
  output logic [GAIN_WIDTH-1:0]        gain,
  output logic                         agc_lock,
  output logic                         sat_flag
);

  localparam int PW  = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int MW  = DATA_WIDTH + 1;
  localparam int AW  = DATA_WIDTH + 1 + WIN_LOG2;
  localparam int EW  = AW + 2;
  localparam int GX  = GAIN_WIDTH + EW;
  localparam int LCW = $clog2(LOCK_WINS + 1);

  localparam logic signed [PW-1:0] RND  = PW'(1 << (GAIN_FRAC - 1));
  localparam logic signed [PW-1:0] DMAX = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] DMIN = -DMAX - PW'(1);
  localparam logic signed [EW-1:0] TGT  = EW'(TARGET);
  localparam logic signed [EW-1:0] TOL1 = EW'(LOCK_TOL);
  localparam logic signed [EW-1:0] TOL2 = EW'(2 * LOCK_TOL);
  localparam logic signed [GX-1:0] GMAX = GX'({GAIN_WIDTH{1'b1}});
  localparam logic signed [GX-1:0] GMIN = GX'(1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, HOLD} state_t;

  typedef struct packed {
    logic                 vld;
    logic signed [PW-1:0] i;
    logic signed [PW-1:0] q;
  } prod_t;

  state_t                  state;
  prod_t                   s1;
  logic signed [GAIN_WIDTH:0] gain_s;
  logic [DATA_WIDTH:0]     rs_i, rs_q;
  logic [MW-1:0]           mag;
  logic [AW-1:0]           acc, acc_sum;
  logic [WIN_LOG2-1:0]     win_cnt;
  logic [LCW-1:0]          lock_cnt;
  logic                    win_end;
  logic signed [EW-1:0]    err, err_abs, step;
  logic signed [GX-1:0]    gain_sum;
  logic [GAIN_WIDTH-1:0]   gain_upd, gain_ld;

  // Returns {clipped, value}: round half up, arithmetic shift, clamp to the sample range.
  function automatic logic [DATA_WIDTH:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND) >>> GAIN_FRAC;
    if (r > DMAX) return {1'b1, DMAX[DATA_WIDTH-1:0]};
    if (r < DMIN) return {1'b1, DMIN[DATA_WIDTH-1:0]};
    return {1'b0, r[DATA_WIDTH-1:0]};
  endfunction

  function automatic logic [MW-1:0] abs_mag(input logic signed [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] a;
    if (x == DMIN[DATA_WIDTH-1:0]) a = DMAX[DATA_WIDTH-1:0];
    else if (x[DATA_WIDTH-1])      a = -x;
    else                           a = x;
    return {1'b0, a};
  endfunction

  assign gain_s = signed'({1'b0, gain});
  assign rs_i   = round_sat(s1.i);
  assign rs_q   = round_sat(s1.q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      dout_I     <= '0;
      dout_Q     <= '0;
      dout_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      s1.vld     <= din_valid;
      s1.i       <= PW'(din_I) * PW'(gain_s);
      s1.q       <= PW'(din_Q) * PW'(gain_s);
      dout_I     <= rs_i[DATA_WIDTH-1:0];
      dout_Q     <= rs_q[DATA_WIDTH-1:0];
      dout_valid <= s1.vld;
      sat_flag   <= s1.vld & (rs_i[DATA_WIDTH] | rs_q[DATA_WIDTH]);
    end
  end

  // Loop measurement taps the registered outputs, so it sees exactly what downstream sees.
  assign mag     = abs_mag(dout_I) + abs_mag(dout_Q);
  assign acc_sum = acc + AW'(mag);
  assign win_end = (win_cnt == '1);
  assign gain_ld = (gain_load_val == '0) ? GAIN_WIDTH'(1) : gain_load_val;

  always_comb begin
    err      = TGT - signed'(EW'(acc_sum >> WIN_LOG2));
    err_abs  = err[EW-1] ? -err : err;
    step     = (state == TRACK) ? (err >>> MU_TRK_SHIFT) : (err >>> MU_ACQ_SHIFT);
    gain_sum = GX'(gain_s) + GX'(step);
    if (gain_sum < GMIN)      gain_upd = GAIN_WIDTH'(1);
    else if (gain_sum > GMAX) gain_upd = '1;
    else                      gain_upd = gain_sum[GAIN_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gain     <= GAIN_WIDTH'(GAIN_INIT);
      acc      <= '0;
      win_cnt  <= '0;
      lock_cnt <= '0;
      agc_lock <= 1'b0;
    end else if (gain_load) begin
      gain     <= gain_ld;
      acc      <= '0;
      win_cnt  <= '0;
      lock_cnt <= '0;
      agc_lock <= 1'b0;
      if (!agc_en)     state <= IDLE;
      else if (freeze) state <= HOLD;
      else             state <= ACQUIRE;
    end else if (!agc_en) begin
      state    <= IDLE;
      acc      <= '0;
      win_cnt  <= '0;
      lock_cnt <= '0;
      agc_lock <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= ACQUIRE;
          acc     <= '0;
          win_cnt <= '0;
        end
        HOLD: begin
          acc     <= '0;
          win_cnt <= '0;
          if (!freeze) state <= agc_lock ? TRACK : ACQUIRE;
        end
        default: begin
          if (freeze) begin
            state   <= HOLD;
            acc     <= '0;
            win_cnt <= '0;
          end else if (dout_valid) begin
            if (win_end) begin
              acc     <= '0;
              win_cnt <= '0;
              gain    <= gain_upd;
              if (state == ACQUIRE) begin
                if (err_abs <= TOL1) begin
                  if (lock_cnt == LCW'(LOCK_WINS - 1)) begin
                    state    <= TRACK;
                    agc_lock <= 1'b1;
                    lock_cnt <= '0;
                  end else begin
                    lock_cnt <= lock_cnt + LCW'(1);
                  end
                end else begin
                  lock_cnt <= '0;
                end
              end else if (err_abs > TOL2) begin
                state    <= ACQUIRE;
                agc_lock <= 1'b0;
                lock_cnt <= '0;
              end
            end else begin
              acc     <= acc_sum;
              win_cnt <= win_cnt + WIN_LOG2'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_agc.sv
// Bench for rx_agc: fixed-gain vector table, reset/convergence/freeze/disturbance sequences,
// and randomized traffic against a sample-level reference model of the gain loop.
module tb_rx_agc;
  localparam int DW = 12;
  localparam int GW = 16;

  typedef enum int {M_OFF, M_ACQ, M_TRK, M_HOLD} mode_e;
  typedef struct {
    int g; int di; int dq; int eg; int ei; int eq; int esat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [DW-1:0] din_I = '0, din_Q = '0;
  logic din_valid = 1'b0, agc_en = 1'b0, freeze = 1'b0, gain_load = 1'b0;
  logic [GW-1:0] gain_load_val = '0;
  logic signed [DW-1:0] dout_I, dout_Q;
  logic dout_valid, agc_lock, sat_flag;
  logic [GW-1:0] gain;

  always #5 clk = ~clk;

  rx_agc dut (
    .clk(clk), .rst_n(rst_n), .din_I(din_I), .din_Q(din_Q), .din_valid(din_valid),
    .agc_en(agc_en), .freeze(freeze), .gain_load(gain_load), .gain_load_val(gain_load_val),
    .dout_I(dout_I), .dout_Q(dout_Q), .dout_valid(dout_valid), .gain(gain),
    .agc_lock(agc_lock), .sat_flag(sat_flag)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: sample-level view of the two-stage datapath and the window loop.
  int m_gain, m_acc, m_cnt, m_lc, m_lock;
  mode_e m_mode;
  int a_v, a_i, a_q, b_v, b_i, b_q, b_sat;

  function automatic int fdiv(int a, int sh);
    int d = 1 << sh;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clampi(int x, int lo, int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic int absm(int x);
    if (x == -2048) return 2047;
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_gain = 1443; m_acc = 0; m_cnt = 0; m_lc = 0; m_lock = 0; m_mode = M_OFF;
    a_v = 0; a_i = 0; a_q = 0; b_v = 0; b_i = 0; b_q = 0; b_sat = 0;
  endtask

  task automatic model_step();
    int g0, r_i, r_q, nsat, mg, mean, err, ae;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g0 = m_gain;
    r_i = fdiv(a_i + 512, 10);
    r_q = fdiv(a_q + 512, 10);
    nsat = (a_v != 0 && (r_i != clampi(r_i, -2048, 2047) || r_q != clampi(r_q, -2048, 2047))) ? 1 : 0;
    if (gain_load) begin
      m_gain = (gain_load_val == 0) ? 1 : int'(gain_load_val);
      m_acc = 0; m_cnt = 0; m_lc = 0; m_lock = 0;
      m_mode = !agc_en ? M_OFF : (freeze ? M_HOLD : M_ACQ);
    end else if (!agc_en) begin
      m_mode = M_OFF; m_acc = 0; m_cnt = 0; m_lc = 0; m_lock = 0;
    end else begin
      case (m_mode)
        M_OFF: begin m_mode = M_ACQ; m_acc = 0; m_cnt = 0; end
        M_HOLD: begin
          m_acc = 0; m_cnt = 0;
          if (!freeze) m_mode = (m_lock != 0) ? M_TRK : M_ACQ;
        end
        default: begin
          if (freeze) begin
            m_mode = M_HOLD; m_acc = 0; m_cnt = 0;
          end else if (b_v != 0) begin
            mg = absm(b_i) + absm(b_q);
            if (m_cnt == 63) begin
              mean = (m_acc + mg) / 64;
              err = 1024 - mean;
              m_gain = clampi(m_gain + fdiv(err, (m_mode == M_TRK) ? 7 : 4), 1, 65535);
              m_acc = 0; m_cnt = 0;
              ae = (err < 0) ? -err : err;
              if (m_mode == M_ACQ) begin
                if (ae <= 128) begin
                  m_lc++;
                  if (m_lc == 4) begin m_mode = M_TRK; m_lock = 1; m_lc = 0; end
                end else m_lc = 0;
              end else if (ae > 256) begin
                m_mode = M_ACQ; m_lock = 0; m_lc = 0;
              end
            end else begin
              m_acc += mg; m_cnt++;
            end
          end
        end
      endcase
    end
    b_v = a_v; b_i = clampi(r_i, -2048, 2047); b_q = clampi(r_q, -2048, 2047); b_sat = nsat;
    a_v = din_valid ? 1 : 0;
    a_i = int'(din_I) * g0;
    a_q = int'(din_Q) * g0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("cyc", {dout_valid, sat_flag, agc_lock, dout_I, dout_Q, gain},
          {b_v[0], b_sat[0], m_lock[0], b_i[11:0], b_q[11:0], m_gain[15:0]});
  endtask

  vec_t tbl[8];

  initial begin
    int n, dec, prev, gfrz, nchg, gl, amp;
    tbl[0] = '{1024, 1000, -1000, 1024, 1000, -1000, 0};
    tbl[1] = '{1443, 2047, 0, 1443, 2047, 0, 1};
    tbl[2] = '{1536, 3, -3, 1536, 5, -4, 0};
    tbl[3] = '{1024, -2048, 2047, 1024, -2048, 2047, 0};
    tbl[4] = '{2048, -2048, 1024, 2048, -2048, 2047, 1};
    tbl[5] = '{512, 1, -1, 512, 1, 0, 0};
    tbl[6] = '{0, 2047, -2048, 1, 2, -2, 0};
    tbl[7] = '{65535, 1, -1, 65535, 64, -64, 0};

    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Fixed-gain table with the loop disabled
    for (int k = 0; k < 8; k++) begin
      gain_load = 1'b1; gain_load_val = GW'(tbl[k].g); din_valid = 1'b0;
      cyc();
      gain_load = 1'b0;
      check("tbl_gain", gain, tbl[k].eg);
      din_I = DW'(tbl[k].di); din_Q = DW'(tbl[k].dq); din_valid = 1'b1;
      cyc();
      check("tbl_lat1_valid", dout_valid, 0);
      din_valid = 1'b0;
      cyc();
      check("tbl_valid", dout_valid, 1);
      check("tbl_I", dout_I, tbl[k].ei);
      check("tbl_Q", dout_Q, tbl[k].eq);
      check("tbl_sat", sat_flag, tbl[k].esat);
    end

    // Asynchronous reset mid-stream
    for (int k = 0; k < 10; k++) begin
      din_I = DW'($urandom); din_Q = DW'($urandom); din_valid = 1'b1;
      cyc();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_I", dout_I, 0);
    check("rst_Q", dout_Q, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_gain", gain, 1443);
    check("rst_lock", agc_lock, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_rel_valid1", dout_valid, 0);
    cyc();
    check("rst_rel_valid2", dout_valid, 1);

    // Convergence on a constant input
    din_I = 12'sd256; din_Q = 12'sd256; din_valid = 1'b1; agc_en = 1'b1;
    n = 0; dec = 0; prev = 1443;
    while (agc_lock !== 1'b1 && n < 200 * 64 + 8) begin
      cyc();
      if (int'(gain) < prev) dec++;
      prev = int'(gain);
      n++;
    end
    check("lock_within_200w", agc_lock, 1);
    while (n < 400 * 64) begin
      cyc();
      if (int'(gain) < prev) dec++;
      prev = int'(gain);
      n++;
    end
    check("gain_monotonic", dec, 0);
    check("gain_rose", gain > 16'd1600, 1);

    // Freeze after lock
    freeze = 1'b1; gfrz = m_gain; nchg = 0;
    repeat (640) begin
      cyc();
      if (int'(gain) != gfrz) nchg++;
    end
    check("frz_gain_const", nchg, 0);
    check("frz_lock_kept", agc_lock, 1);
    freeze = 1'b0;
    repeat (3 * 64) cyc();
    check("frz_release_lock", agc_lock, 1);

    // gain_load 0 mid-window while locked, then reload and relock
    repeat (20) cyc();
    gl = m_gain;
    gain_load = 1'b1; gain_load_val = '0;
    cyc();
    gain_load = 1'b0;
    check("load0_gain", gain, 1);
    check("load0_lock", agc_lock, 0);
    gain_load = 1'b1; gain_load_val = GW'(gl);
    cyc();
    gain_load = 1'b0;
    n = 0;
    while (agc_lock !== 1'b1 && n < 20 * 64) begin cyc(); n++; end
    check("relock", agc_lock, 1);

    // Step disturbance while locked
    din_I = 12'sd1024; din_Q = 12'sd1024;
    n = 0;
    while (agc_lock === 1'b1 && n < 140) begin cyc(); n++; end
    check("step_unlock", agc_lock, 0);

    // Randomized traffic
    for (int seg = 0; seg < 4; seg++) begin
      amp = (seg == 1) ? 16 : ((seg == 2) ? 256 : 2047);
      for (int k = 0; k < 1000; k++) begin
        din_I = DW'(int'($urandom_range(0, 2 * amp)) - amp);
        din_Q = DW'(int'($urandom_range(0, 2 * amp)) - amp);
        din_valid = ($urandom_range(0, 3) != 0);
        agc_en = ($urandom_range(0, 99) != 0);
        freeze = ($urandom_range(0, 49) == 0);
        gain_load = ($urandom_range(0, 299) == 0);
        gain_load_val = GW'($urandom);
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
